// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board pads and the debouncer: raw levels in, clean levels and edge pulses out.
// No handshake: every signal is a level or single-cycle pulse sampled on each rising i_clock edge.
interface switch_debouncer_if #(
  parameter int NUM_SW = 3
);
  logic [NUM_SW-1:0] i_sw;
  logic [NUM_SW-1:0] o_sw;
  logic [NUM_SW-1:0] o_rise;
  logic [NUM_SW-1:0] o_fall;

  modport master (output i_sw, input o_sw, input o_rise, input o_fall);
  modport slave  (input i_sw, output o_sw, output o_rise, output o_fall);
endinterface

// File: rtl/switch_debouncer.sv
// Per-channel 2-flop synchroniser, stable-level debounce counter and one-cycle rise/fall pulse generator.
module switch_debouncer #(
  parameter int NUM_SW         = 3,
  parameter int DEBOUNCE_COUNT = 250
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  switch_debouncer_if.slave   bus
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_COUNT - 1);

  logic [NUM_SW-1:0] sync1;
  logic [NUM_SW-1:0] sync2;
  logic [NUM_SW-1:0] sw_q;
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] fall_q;
  logic [15:0]       count [NUM_SW];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int n = 0; n < NUM_SW; n++) count[n] <= '0;
    end else begin
      sync1 <= bus.i_sw;
      sync2 <= sync1;
      for (int n = 0; n < NUM_SW; n++) begin
        rise_q[n] <= 1'b0;
        fall_q[n] <= 1'b0;
        // Any cycle agreeing with the accepted level restarts the stability window.
        if (sync2[n] == sw_q[n]) begin
          count[n] <= '0;
        end else if (count[n] == LAST_COUNT) begin
          sw_q[n]   <= sync2[n];
          count[n]  <= '0;
          rise_q[n] <= sync2[n];
          fall_q[n] <= ~sync2[n];
        end else begin
          count[n] <= count[n] + 16'd1;
        end
      end
    end
  end

  assign bus.o_sw   = sw_q;
  assign bus.o_rise = rise_q;
  assign bus.o_fall = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with NUM_SW=3, DEBOUNCE_COUNT=4 (acceptance on the 6th edge after a new level).
module tb_switch_debouncer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  switch_debouncer_if #(.NUM_SW(3)) bus ();

  switch_debouncer #(
    .NUM_SW         (3),
    .DEBOUNCE_COUNT (4)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] sw_e,
                           input logic [2:0] rise_e, input logic [2:0] fall_e);
    check({tag, ".sw"},   bus.o_sw,   sw_e);
    check({tag, ".rise"}, bus.o_rise, rise_e);
    check({tag, ".fall"}, bus.o_fall, fall_e);
  endtask

  logic [7:0] bounce_pat;

  initial begin
    checks     = 0;
    errors     = 0;
    bounce_pat = 8'b0111_0111;  // driven LSB first: 1,1,1,0,1,1,1,0
    rst_n      = 1'b0;
    bus.i_sw   = 3'b111;

    // Reset with all switches high
    #1;
    check_all("reset_imm", 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset_hold", 3'b000, 3'b000, 3'b000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("reset_rel_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    check_all("reset_rel_accept", 3'b111, 3'b111, 3'b000);
    tick();
    check_all("reset_rel_pulse_end", 3'b111, 3'b000, 3'b000);

    // Return to idle: all three fall together
    bus.i_sw = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("idle_wait", 3'b111, 3'b000, 3'b000);
    end
    tick();
    check_all("idle_fall", 3'b000, 3'b000, 3'b111);
    tick();
    check_all("idle_fall_end", 3'b000, 3'b000, 3'b000);

    // Clean rise on channel 0
    bus.i_sw = 3'b001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("clean_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    check_all("clean_rise", 3'b001, 3'b001, 3'b000);
    tick();
    check_all("clean_rise_end", 3'b001, 3'b000, 3'b000);

    // Bounce on channel 1, never 4 stable cycles
    for (int i = 0; i < 8; i++) begin
      bus.i_sw = {1'b0, bounce_pat[i], 1'b1};
      tick();
      check_all("bounce_pat", 3'b001, 3'b000, 3'b000);
    end
    bus.i_sw = 3'b011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("bounce_settle", 3'b001, 3'b000, 3'b000);
    end
    tick();
    check_all("bounce_rise", 3'b011, 3'b010, 3'b000);
    tick();
    check_all("bounce_rise_end", 3'b011, 3'b000, 3'b000);

    // Independent channels: ch2 rises, ch0 falls on the same edge
    bus.i_sw = 3'b110;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("indep_wait", 3'b011, 3'b000, 3'b000);
    end
    tick();
    check_all("indep_edge", 3'b110, 3'b100, 3'b001);
    tick();
    check_all("indep_end", 3'b110, 3'b000, 3'b000);

    // Back to idle before the reset mid-count case
    bus.i_sw = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    check_all("idle2", 3'b000, 3'b000, 3'b000);

    // Reset mid-count on channel 0
    bus.i_sw = 3'b001;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    check_all("midrst_imm", 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all("midrst_hold", 3'b000, 3'b000, 3'b000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("midrst_wait", 3'b000, 3'b000, 3'b000);
    end
    tick();
    check_all("midrst_rise", 3'b001, 3'b001, 3'b000);
    tick();
    check_all("midrst_rise_end", 3'b001, 3'b000, 3'b000);

    // 3-cycle glitch on channel 2 is rejected
    bus.i_sw = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("glitch_high", 3'b001, 3'b000, 3'b000);
    end
    bus.i_sw = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all("glitch_after", 3'b001, 3'b000, 3'b000);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
